// File: rtl/nor_mis_pkg.sv
// Shared types, default widths and helpers for the NOR MIS stimulus generator.
package nor_mis_pkg;

    localparam int unsigned DELTA_W_DEF  = 8;
    localparam int unsigned PERIOD_W_DEF = 8;
    localparam int unsigned CNT_W_DEF    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_LAG_WAIT,
        ST_SETTLE,
        ST_FIN
    } state_e;

    // Magnitude of a sign-extended skew; the most negative value maps to its full magnitude.
    function automatic logic [31:0] delta_mag(input logic signed [31:0] d);
        return d[31] ? 32'(-d) : 32'(d);
    endfunction

endpackage

// File: rtl/nor_mis_down_counter.sv
// Loadable down counter with a zero flag; holds at zero.
module nor_mis_down_counter
    import nor_mis_pkg::*;
#(
    parameter int unsigned W = DELTA_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/nor_mis_stim_gen.sv
// Drives the two NOR chain inputs with skewed toggle events separated by a settle gap.
module nor_mis_stim_gen
    import nor_mis_pkg::*;
#(
    parameter int unsigned DELTA_W  = DELTA_W_DEF,
    parameter int unsigned PERIOD_W = PERIOD_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic signed [DELTA_W-1:0]  delta,
    input  logic [PERIOD_W-1:0]        period,
    input  logic [CNT_W-1:0]           num_events,
    output logic                       myinA1,
    output logic                       myinA2,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           events_done
);

    state_e               state_q, state_d;
    logic                 a1_q, a1_d;
    logic                 a2_q, a2_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     ev_q, ev_d;
    logic [DELTA_W-1:0]   mag_q, mag_d;
    logic                 a1_lead_q, a1_lead_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]     num_q, num_d;

    logic                 lag_load_c, lag_dec_c, lag_zero_c;
    logic [DELTA_W-1:0]   lag_val_c;
    logic                 set_load_c, set_dec_c, set_zero_c;
    logic [PERIOD_W-1:0]  set_val_c;
    logic                 lag_edge_c;
    logic [DELTA_W-1:0]   mag_in_c;

    assign mag_in_c = DELTA_W'(delta_mag(32'(delta)));

    always_comb begin
        state_d    = state_q;
        a1_d       = a1_q;
        a2_d       = a2_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        ev_d       = ev_q;
        mag_d      = mag_q;
        a1_lead_d  = a1_lead_q;
        period_d   = period_q;
        num_d      = num_q;
        lag_load_c = 1'b0;
        lag_dec_c  = 1'b0;
        lag_val_c  = mag_q - DELTA_W'(1);
        set_load_c = 1'b0;
        set_dec_c  = 1'b0;
        set_val_c  = period_q - PERIOD_W'(1);
        lag_edge_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mag_d     = mag_in_c;
                    a1_lead_d = ~delta[DELTA_W-1];
                    period_d  = period;
                    num_d     = num_events;
                    ev_d      = '0;
                    state_d   = (num_events == '0) ? ST_FIN : ST_LEAD;
                end
            end
            ST_LEAD: begin
                busy_d = 1'b1;
                if (mag_q == '0) begin
                    a1_d       = ~a1_q;
                    a2_d       = ~a2_q;
                    lag_edge_c = 1'b1;
                end else begin
                    if (a1_lead_q) a1_d = ~a1_q;
                    else           a2_d = ~a2_q;
                    lag_load_c = 1'b1;
                    state_d    = ST_LAG_WAIT;
                end
            end
            ST_LAG_WAIT: begin
                busy_d = 1'b1;
                if (lag_zero_c) begin
                    if (a1_lead_q) a2_d = ~a2_q;
                    else           a1_d = ~a1_q;
                    lag_edge_c = 1'b1;
                end else begin
                    lag_dec_c = 1'b1;
                end
            end
            ST_SETTLE: begin
                busy_d = 1'b1;
                if (set_zero_c) begin
                    state_d = (ev_q == num_q) ? ST_FIN : ST_LEAD;
                end else begin
                    set_dec_c = 1'b1;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Event completes on the lagging edge; a zero gap skips SETTLE entirely.
        if (lag_edge_c) begin
            ev_d = ev_q + CNT_W'(1);
            if (period_q == '0) begin
                state_d = (ev_d == num_q) ? ST_FIN : ST_LEAD;
            end else begin
                set_load_c = 1'b1;
                state_d    = ST_SETTLE;
            end
        end

        if (abort) begin
            state_d = ST_IDLE;
            a1_d    = 1'b0;
            a2_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            ev_d    = ev_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a1_q      <= 1'b0;
            a2_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ev_q      <= '0;
            mag_q     <= '0;
            a1_lead_q <= 1'b1;
            period_q  <= '0;
            num_q     <= '0;
        end else begin
            state_q   <= state_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ev_q      <= ev_d;
            mag_q     <= mag_d;
            a1_lead_q <= a1_lead_d;
            period_q  <= period_d;
            num_q     <= num_d;
        end
    end

    nor_mis_down_counter #(.W(DELTA_W)) u_lag_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lag_load_c),
        .load_val (lag_val_c),
        .dec      (lag_dec_c),
        .zero_c   (lag_zero_c)
    );

    nor_mis_down_counter #(.W(PERIOD_W)) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (set_load_c),
        .load_val (set_val_c),
        .dec      (set_dec_c),
        .zero_c   (set_zero_c)
    );

    assign myinA1      = a1_q;
    assign myinA2      = a2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign events_done = ev_q;

endmodule

// File: tb/tb_nor_mis_stim_gen.sv
// Self-checking bench for nor_mis_stim_gen: directed table, randomized model check, abort/reset cases.
module tb_nor_mis_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  delta;
    logic [7:0]  period;
    logic [15:0] num_events;
    logic        a1_o, a2_o, busy_o, done_o;
    logic [15:0] ev_o;

    int errors = 0;
    int checks = 0;
    bit model_lvl;

    nor_mis_stim_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .delta       (delta),
        .period      (period),
        .num_events  (num_events),
        .myinA1      (a1_o),
        .myinA2      (a2_o),
        .busy        (busy_o),
        .done        (done_o),
        .events_done (ev_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int p;
        int n;
        int exp_done_edge;
        int exp_ev;
        int exp_a1;
        int exp_a2;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs after relative edge e of a sequence whose start was sampled at edge 0.
    task automatic ref_at(input int e, input int d, input int p, input int n, input bit v0,
                          output int a1, output int a2, output int bz, output int dn, output int ev);
        int m, step, fin, t1, t2, c1, c2, lead, lag;
        m    = (d < 0) ? -d : d;
        step = m + p + 1;
        c1 = 0; c2 = 0; ev = 0;
        if (n == 0) begin
            bz = 0;
            dn = (e == 1) ? 1 : 0;
        end else begin
            fin = 1 + (n - 1) * step + m + p + 1;
            bz  = (e >= 1 && e < fin) ? 1 : 0;
            dn  = (e == fin) ? 1 : 0;
            for (int k = 0; k < n; k++) begin
                lead = 1 + k * step;
                lag  = lead + m;
                t1   = (d >= 0) ? lead : lag;
                t2   = (d > 0) ? lag : lead;
                if (t1 <= e) c1++;
                if (t2 <= e) c2++;
                if (lag <= e) ev++;
            end
        end
        a1 = int'(v0) ^ (c1 % 2);
        a2 = int'(v0) ^ (c2 % 2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_lvl = 1'b0;
    endtask

    task automatic kick(input int d, input int p, input int n);
        @(posedge clk); #1;
        start = 1'b1; delta = 8'(d); period = 8'(p); num_events = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        delta = 8'($urandom); period = 8'($urandom); num_events = 16'($urandom);
    endtask

    // Cycle-by-cycle comparison of one sequence against the arithmetic model.
    task automatic run_seq(input int d, input int p, input int n, input int inj);
        int a1, a2, bz, dn, ev, m, fin;
        m   = (d < 0) ? -d : d;
        fin = (n == 0) ? 1 : 1 + (n - 1) * (m + p + 1) + m + p + 1;
        kick(d, p, n);
        for (int e = 1; e <= fin + 2; e++) begin
            start = (e == inj);
            @(posedge clk); #1;
            start = 1'b0;
            ref_at(e, d, p, n, model_lvl, a1, a2, bz, dn, ev);
            chk($sformatf("a1 d=%0d e=%0d", d, e), int'(a1_o), a1);
            chk($sformatf("a2 d=%0d e=%0d", d, e), int'(a2_o), a2);
            chk($sformatf("busy d=%0d e=%0d", d, e), int'(busy_o), bz);
            chk($sformatf("done d=%0d e=%0d", d, e), int'(done_o), dn);
            chk($sformatf("events d=%0d e=%0d", d, e), int'(ev_o), ev);
        end
        if (n % 2 == 1) model_lvl = ~model_lvl;
    endtask

    initial begin
        vec_t vecs[7];
        int   first, pulses, busy_seen, rd, rp, rn;

        vecs[0] = '{d:   3, p:   2, n: 2, exp_done_edge:  13, exp_ev: 2, exp_a1: 0, exp_a2: 0};
        vecs[1] = '{d:  -2, p:   1, n: 1, exp_done_edge:   5, exp_ev: 1, exp_a1: 1, exp_a2: 1};
        vecs[2] = '{d:   0, p:   0, n: 4, exp_done_edge:   5, exp_ev: 4, exp_a1: 0, exp_a2: 0};
        vecs[3] = '{d:-128, p:   0, n: 1, exp_done_edge: 130, exp_ev: 1, exp_a1: 1, exp_a2: 1};
        vecs[4] = '{d:   0, p:   3, n: 0, exp_done_edge:   1, exp_ev: 0, exp_a1: 0, exp_a2: 0};
        vecs[5] = '{d:   1, p:   0, n: 3, exp_done_edge:   7, exp_ev: 3, exp_a1: 1, exp_a2: 1};
        vecs[6] = '{d: 127, p: 255, n: 1, exp_done_edge: 384, exp_ev: 1, exp_a1: 1, exp_a2: 1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        delta = '0; period = '0; num_events = '0;
        #12;
        chk("reset a1", int'(a1_o), 0);
        chk("reset a2", int'(a2_o), 0);
        chk("reset busy", int'(busy_o), 0);
        chk("reset done", int'(done_o), 0);
        chk("reset events", int'(ev_o), 0);
        rst_n = 1'b1;

        // Directed table: completion edge, single done pulse, final state.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            kick(vecs[i].d, vecs[i].p, vecs[i].n);
            first = -1; pulses = 0; busy_seen = 0;
            for (int e = 1; e <= vecs[i].exp_done_edge + 5; e++) begin
                @(posedge clk); #1;
                if (busy_o) busy_seen = 1;
                if (done_o) begin
                    pulses++;
                    if (first < 0) first = e;
                end
            end
            chk($sformatf("vec%0d done_edge", i), first, vecs[i].exp_done_edge);
            chk($sformatf("vec%0d done_pulses", i), pulses, 1);
            chk($sformatf("vec%0d events", i), int'(ev_o), vecs[i].exp_ev);
            chk($sformatf("vec%0d a1", i), int'(a1_o), vecs[i].exp_a1);
            chk($sformatf("vec%0d a2", i), int'(a2_o), vecs[i].exp_a2);
            chk($sformatf("vec%0d busy_seen", i), busy_seen, (vecs[i].n != 0) ? 1 : 0);
            chk($sformatf("vec%0d busy_end", i), int'(busy_o), 0);
        end

        // Model-checked sequences, including a start issued while busy.
        do_reset();
        run_seq(3, 2, 2, -1);
        run_seq(3, 2, 2, 3);
        run_seq(-2, 0, 1, -1);
        run_seq(0, 1, 4, 2);
        for (int i = 0; i < 10; i++) begin
            rd = int'($urandom_range(0, 40)) - 20;
            rp = int'($urandom_range(0, 6));
            rn = int'($urandom_range(0, 5));
            run_seq(rd, rp, rn, -1);
        end

        // Abort during the second event's lag wait.
        do_reset();
        kick(10, 2, 3);
        repeat (17) @(posedge clk);
        #1;
        chk("pre-abort a1", int'(a1_o), 0);
        chk("pre-abort a2", int'(a2_o), 1);
        chk("pre-abort events", int'(ev_o), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort a1", int'(a1_o), 0);
        chk("abort a2", int'(a2_o), 0);
        chk("abort busy", int'(busy_o), 0);
        chk("abort done", int'(done_o), 0);
        chk("abort events", int'(ev_o), 1);
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            chk($sformatf("post-abort done e=%0d", e), int'(done_o), 0);
            chk($sformatf("post-abort busy e=%0d", e), int'(busy_o), 0);
            chk($sformatf("post-abort a2 e=%0d", e), int'(a2_o), 0);
        end

        // Start and abort together in IDLE: nothing starts.
        do_reset();
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; delta = 8'(1); period = 8'(0); num_events = 16'(1);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            chk($sformatf("st+ab busy e=%0d", e), int'(busy_o), 0);
            chk($sformatf("st+ab a1 e=%0d", e), int'(a1_o), 0);
            chk($sformatf("st+ab done e=%0d", e), int'(done_o), 0);
        end

        // Asynchronous reset in the middle of a settle gap.
        do_reset();
        kick(1, 20, 2);
        repeat (4) @(posedge clk);
        #1;
        chk("pre-rst events", int'(ev_o), 1);
        chk("pre-rst a1", int'(a1_o), 1);
        chk("pre-rst busy", int'(busy_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst a1", int'(a1_o), 0);
        chk("midrst a2", int'(a2_o), 0);
        chk("midrst busy", int'(busy_o), 0);
        chk("midrst done", int'(done_o), 0);
        chk("midrst events", int'(ev_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
